// File: rtl/wrong_time_counter_pkg.sv
// wrong_time_counter_pkg
//   Shared definitions for the wrong_time_counter slice: judge FSM state
//   encodings, tick counter width and button count.
package wrong_time_counter_pkg;

  // Width of the window/cooldown tick counter (covers 1..4095 ticks).
  localparam int TICK_W = 12;

  // Number of player buttons.
  localparam int BTN_W = 4;

  // Judge FSM states, 3-bit encoded.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_TGT = 3'd1,
    ST_WINDOW   = 3'd2,
    ST_COOL     = 3'd3,
    ST_OVER     = 3'd4
  } state_t;

endpackage

// File: rtl/wrong_time_counter_btn_sync_edge.sv
// btn_sync_edge
//   Brings the raw asynchronous buttons into the clk domain with a 2-flop
//   synchronizer per bit, then emits a registered one-cycle pulse on each
//   rising edge. A pin change is seen by the consumer on the third clk edge.
// Ports
//   clk    in  1      system clock
//   rst_n  in  1      asynchronous active-low reset
//   btn    in  BTN_W  raw active-high buttons, asynchronous to clk
//   rise   out BTN_W  one-cycle rising-edge pulses, registered
module btn_sync_edge
  import wrong_time_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BTN_W-1:0] btn,
  output logic [BTN_W-1:0] rise
);

  logic [BTN_W-1:0] sync1;
  logic [BTN_W-1:0] sync2;
  logic [BTN_W-1:0] sync3;

  // NOTE: every flop here, synchronizer stages included, is written with
  // non-blocking assignments so each stage samples the previous stage's old
  // value; blocking writes would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      rise  <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      rise  <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/wrong_time_counter.sv
// wrong_time_counter
//   Judges each target round of the reaction game and keeps the 3-bit miss
//   count that drives the fail LED display. A correct button edge inside the
//   reaction window is a hit; a wrong button or a window timeout is a miss.
//   Reaching MAX_WRONG misses ends the game until the next new_game.
// Parameters
//   WINDOW_TICKS  reaction window length in tick pulses (1..4095)
//   COOL_TICKS    dead time after each judgement in tick pulses (1..4095)
//   MAX_WRONG     miss count that ends the game (1..7)
// Ports
//   clk           in  1  system clock
//   rst_n         in  1  asynchronous active-low reset
//   tick          in  1  one-cycle timebase enable
//   new_game      in  1  clear count and start judging (priority in all states)
//   target_valid  in  1  new target shown; opens the window from WAIT_TGT
//   target_id     in  2  index of the correct button, sampled with target_valid
//   btn           in  4  raw active-high buttons, asynchronous to clk
//   wrong_time    out 3  miss count, saturates at MAX_WRONG
//   game_over     out 1  high from the MAX_WRONG-th miss until new_game/reset
//   hit_pulse     out 1  one-cycle pulse per judged hit
//   miss_pulse    out 1  one-cycle pulse per judged miss
module wrong_time_counter
  import wrong_time_counter_pkg::*;
#(
  parameter int WINDOW_TICKS = 500,
  parameter int COOL_TICKS   = 100,
  parameter int MAX_WRONG    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       new_game,
  input  logic       target_valid,
  input  logic [1:0] target_id,
  input  logic [3:0] btn,
  output logic [2:0] wrong_time,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam logic [TICK_W-1:0] WIN_LAST  = TICK_W'(WINDOW_TICKS - 1);
  localparam logic [TICK_W-1:0] COOL_LAST = TICK_W'(COOL_TICKS - 1);
  localparam logic [2:0]        MAX_W     = 3'(MAX_WRONG);

  logic [BTN_W-1:0]  rise;
  state_t            state;
  logic [TICK_W-1:0] cnt;
  logic [1:0]        tgt;

  btn_sync_edge u_btn_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .rise  (rise)
  );

  // Judgement terms for the WINDOW state.
  logic [BTN_W-1:0] tgt_mask;
  logic             any_edge;
  logic             wrong_edge;
  logic             timeout;
  logic [2:0]       wt_next;

  assign tgt_mask   = 4'b0001 << tgt;
  assign any_edge   = |rise;
  // Any non-target bit makes the edge a miss, even alongside the target bit.
  assign wrong_edge = |(rise & ~tgt_mask);
  // The tick that would bring the counter to WINDOW_TICKS is the timeout.
  assign timeout    = tick && (cnt == WIN_LAST);
  assign wt_next    = (wrong_time == MAX_W) ? wrong_time : wrong_time + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tgt        <= '0;
      wrong_time <= '0;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (new_game) begin
        // Abandons any round in flight silently: no pulse for it.
        state      <= ST_WAIT_TGT;
        cnt        <= '0;
        wrong_time <= '0;
        game_over  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_WAIT_TGT: begin
            if (target_valid) begin
              tgt   <= target_id;
              cnt   <= '0;
              state <= ST_WINDOW;
            end
          end
          ST_WINDOW: begin
            // An edge outranks a timeout landing in the same cycle.
            if (any_edge || timeout) begin
              cnt <= '0;
              if (any_edge && !wrong_edge) begin
                hit_pulse <= 1'b1;
                state     <= ST_COOL;
              end else begin
                miss_pulse <= 1'b1;
                wrong_time <= wt_next;
                if (wt_next == MAX_W) begin
                  game_over <= 1'b1;
                  state     <= ST_OVER;
                end else begin
                  state <= ST_COOL;
                end
              end
            end else if (tick) begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_COOL: begin
            if (tick) begin
              if (cnt == COOL_LAST) begin
                cnt   <= '0;
                state <= ST_WAIT_TGT;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_OVER: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wrong_time_counter.sv
// tb_wrong_time_counter
//   Directed stimulus for wrong_time_counter with a scoreboard: each expected
//   judgement is queued by the stimulus, and a monitor pops and compares
//   whenever hit_pulse or miss_pulse is seen. Any pulse with nothing queued
//   is reported as unexpected.
module tb_wrong_time_counter;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [2:0] wt;
    logic       go;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       new_game;
  logic       target_valid;
  logic [1:0] target_id;
  logic [3:0] btn;
  logic [2:0] wrong_time;
  logic       game_over;
  logic       hit_pulse;
  logic       miss_pulse;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  wrong_time_counter #(
    .WINDOW_TICKS (500),
    .COOL_TICKS   (100),
    .MAX_WRONG    (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .new_game     (new_game),
    .target_valid (target_valid),
    .target_id    (target_id),
    .btn          (btn),
    .wrong_time   (wrong_time),
    .game_over    (game_over),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every judgement pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (hit_pulse || miss_pulse)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, hit_pulse, miss_pulse}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse", {26'd0, hit_pulse, miss_pulse, wrong_time, game_over},
              {26'd0, e});
      end
    end
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic press(input logic [3:0] bits);
    @(negedge clk) btn = bits;
    repeat (4) @(negedge clk);
    btn = 4'b0;
    repeat (4) @(negedge clk);
  endtask

  // Edge reaches the judge on the same clk edge as the tick raised here.
  task automatic press_on_tick(input logic [3:0] bits);
    @(negedge clk) btn = bits;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    btn = 4'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic show_target(input logic [1:0] id);
    @(negedge clk) begin
      target_id    = id;
      target_valid = 1'b1;
    end
    @(negedge clk) target_valid = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
  endtask

  task automatic expect_pulse(input logic hit, input logic [2:0] wt, input logic go);
    exp_t e;
    e.hit  = hit;
    e.miss = ~hit;
    e.wt   = wt;
    e.go   = go;
    sb.push_back(e);
  endtask

  // Wait, within a bounded number of cycles, for the queue to drain.
  task automatic drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tick = 1'b0; new_game = 1'b0; target_valid = 1'b0;
    target_id = 2'd0; btn = 4'b0;
    repeat (3) @(negedge clk);
    check("reset_wt", wrong_time, 0);
    check("reset_go", game_over, 0);
    check("reset_pulses", {hit_pulse, miss_pulse}, 0);
    rst_n = 1'b1;

    // IDLE ignores targets and buttons.
    show_target(2'd1);
    press(4'b0010);
    ticks(3);

    // 1: hit at tick 100, then exactly 100 cooldown ticks.
    start_game();
    show_target(2'd2);
    ticks(100);
    expect_pulse(1'b1, 3'd0, 1'b0);
    press(4'b0100);
    drain("hit_basic");
    ticks(99);
    show_target(2'd0);    // still in COOL: dropped
    press(4'b0001);       // ignored in COOL
    ticks(1);
    press(4'b0001);       // ignored in WAIT_TGT
    check("wt_after_cool", wrong_time, 0);

    // 2: wrong button, then correct+wrong in the same cycle.
    show_target(2'd1);
    expect_pulse(1'b0, 3'd1, 1'b0);
    press(4'b1000);
    drain("miss_wrong_btn");
    ticks(100);
    show_target(2'd1);
    expect_pulse(1'b0, 3'd2, 1'b0);
    press(4'b0011);
    drain("miss_mixed_btn");
    ticks(100);

    // 5: new_game mid-window with wrong_time=2.
    show_target(2'd0);
    ticks(50);
    check("wt_before_ng", wrong_time, 2);
    start_game();
    check("ng_wt", wrong_time, 0);
    check("ng_go", game_over, 0);
    press(4'b0001);       // WAIT_TGT: ignored

    // 3: timeout on the 500th tick, and edge on that tick decides.
    show_target(2'd3);
    ticks(499);
    expect_pulse(1'b0, 3'd1, 1'b0);
    ticks(1);
    drain("timeout_miss");
    ticks(100);
    show_target(2'd3);
    ticks(499);
    expect_pulse(1'b1, 3'd1, 1'b0);
    press_on_tick(4'b1000);
    drain("edge_beats_timeout");
    ticks(100);

    // 4: reach MAX_WRONG, then everything is frozen.
    show_target(2'd2);
    expect_pulse(1'b0, 3'd2, 1'b0);
    press(4'b0001);
    drain("miss_two");
    ticks(100);
    show_target(2'd0);
    expect_pulse(1'b0, 3'd3, 1'b1);
    press(4'b0010);
    drain("miss_game_over");
    show_target(2'd1);
    press(4'b0010);
    press(4'b0001);
    ticks(600);
    check("over_wt", wrong_time, 3);
    check("over_go", game_over, 1);

    // 6: async reset mid-window.
    start_game();
    check("restart_go", game_over, 0);
    show_target(2'd1);
    expect_pulse(1'b0, 3'd1, 1'b0);
    press(4'b0001);
    drain("miss_pre_reset");
    ticks(100);
    show_target(2'd1);
    ticks(10);
    check("wt_pre_reset", wrong_time, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_wt", wrong_time, 0);
    check("async_go", game_over, 0);
    @(negedge clk) rst_n = 1'b1;
    press(4'b0010);       // IDLE after reset: ignored
    start_game();
    show_target(2'd1);
    expect_pulse(1'b1, 3'd0, 1'b0);
    press(4'b0010);
    drain("hit_after_reset");
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
